stream_burst_arbiter: RTL
=========================

STREAM_BURST_ARBITER -- requirements
Module: stream_burst_arbiter

Interface
REQ-001 SHALL have parameter NUM_INP, default 4: number of input streams, minimum 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: payload width per beat.
REQ-003 SHALL have port clk_i, input, 1: clock; single clock domain, all logic on rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i, input, 1: synchronous clear of FSM and round-robin pointer.
REQ-006 SHALL have port inp_valid_i, input, NUM_INP: per-input beat valid.
REQ-007 SHALL have port inp_last_i, input, NUM_INP: per-input last beat of burst.
REQ-008 SHALL have port inp_data_i, input, NUM_INP x DATA_WIDTH: per-input payload.
REQ-009 SHALL have port inp_ready_o, output, NUM_INP: per-input beat accepted.
REQ-010 SHALL have port oup_valid_o, output, 1: output beat valid.
REQ-011 SHALL have port oup_last_o, output, 1: output last beat.
REQ-012 SHALL have port oup_data_o, output, DATA_WIDTH: output payload.
REQ-013 SHALL have port oup_idx_o, output, $clog2(NUM_INP): index of the granted input.
REQ-014 SHALL have port oup_ready_i, input, 1: downstream accepts beat.

Function
REQ-015 SHALL implement FSM with states IDLE and LOCKED plus register rr_q, the last granted index.
REQ-016 SHALL, in IDLE, select the first valid input searching upward from rr_q+1 with wrap-around to 0 (lookahead, no step-by-one), all combinationally, with zero-cycle latency from inp_valid_i to oup_valid_o.
REQ-017 SHALL, in LOCKED, forward only the input held in lock_idx_q and ignore all other inputs.
REQ-018 SHALL drive oup_valid_o, oup_last_o and oup_data_o from the selected input, with oup_valid_o=0 when no input is selected.
REQ-019 SHALL assert inp_ready_o[k] only for the selected k when oup_ready_i=1, so inp_ready_o is one-hot or zero.
REQ-020 SHALL define handshake as oup_valid_o & oup_ready_i.
REQ-021 SHALL, in IDLE with oup_valid_o=1, load rr_q with the selected index.
REQ-022 SHALL, in IDLE with oup_valid_o=1 and no handshake on a last beat, go to LOCKED with lock_idx_q=selected index, so a stalled beat or an open burst never changes grant.
REQ-023 SHALL keep an IDLE handshake with last=1 in IDLE, with the next cycle arbitrating from the new rr_q.
REQ-024 SHALL return LOCKED to IDLE on a handshake with oup_last_o=1, and SHALL NOT change rr_q while in LOCKED.
REQ-025 SHALL, in LOCKED with inp_valid_i[lock_idx_q]=0, output oup_valid_o=0 and stay LOCKED (bubble inside a burst).
REQ-026 SHALL drive oup_idx_o as the selected index, or lock_idx_q in LOCKED, and as 0 when idle with no valid input.
REQ-027 SHALL give flush_i priority over every other update: next cycle state=IDLE, rr_q=NUM_INP-1, lock_idx_q=0, and a beat accepted in the flush cycle is still delivered.
REQ-028 SHALL assume inputs keep valid, data and last stable until handshake; this is checked by simulation-only assertions, along with inp_ready_o one-hot and oup_valid_o implying inp_valid_i[oup_idx_o].

Reset
REQ-029 SHALL, while rst_ni=0, force state=IDLE, rr_q=NUM_INP-1 (so input 0 wins the first contention), and lock_idx_q=0.
REQ-030 SHALL produce reset-state outputs of oup_valid_o=0, oup_last_o=0, inp_ready_o=0 and oup_idx_o=0 when all inp_valid_i=0, with oup_data_o equal to input 0 data or 0.
REQ-031 SHALL abandon an open burst on reset assertion mid-burst, and SHALL restart arbitration from IDLE after release.

Configuration
REQ-032 SHALL, with macro STREAM_BURST_ARB_PRIO_EN defined, select input 0 in IDLE whenever inp_valid_i[0]=1, regardless of rr_q, and still update rr_q to 0; an already LOCKED burst is never preempted.
REQ-033 SHALL, without STREAM_BURST_ARB_PRIO_EN, use pure round-robin for all inputs, with no priority logic synthesized.

Verification
REQ-034 Bench SHALL cover, NUM_INP=4, after reset with all inputs valid, single-beat, ready=1: grants 0,1,2,3,0 on consecutive cycles.
REQ-035 Bench SHALL cover input 2 sending a 3-beat burst while inputs 0,1 are valid: idx=2 for 3 handshakes, inp_ready_o[0/1]=0, then input 3 if valid, else 0.
REQ-036 Bench SHALL cover oup_ready_i=0 for 5 cycles while input 1 is valid and input 0 then rises: oup_idx_o stays 1, data stable, then input 1's beat is delivered.
REQ-037 Bench SHALL cover a burst from input 3 with inp_valid_i[3] dropped for 2 cycles mid-burst while input 0 is valid: oup_valid_o=0 for those cycles, grant stays 3 until last.
REQ-038 Bench SHALL cover flush_i pulsed while LOCKED on input 1: next cycle IDLE, and input 0 wins when 0 and 1 are valid.
REQ-039 Bench SHALL cover, with STREAM_BURST_ARB_PRIO_EN defined and inputs 0 and 2 continuously valid single-beat: input 0 granted every cycle, input 2 never; without the macro they alternate 0,2,0,2.

Source files
------------

// File: rtl/stream_burst_arbiter.sv
// stream_burst_arbiter: burst-aware round-robin arbiter for NUM_INP valid/ready streams.
// Once an input wins, it keeps the grant until its last beat is accepted. A stalled
// beat or an open burst therefore never changes the grant.
// Optional build macro STREAM_BURST_ARB_PRIO_EN: input 0 wins every idle arbitration
// in which it is valid. It never preempts a locked burst.
module stream_burst_arbiter #(
    parameter int unsigned NUM_INP    = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 flush_i,
    input  logic [NUM_INP-1:0]                   inp_valid_i,
    input  logic [NUM_INP-1:0]                   inp_last_i,
    input  logic [NUM_INP-1:0][DATA_WIDTH-1:0]   inp_data_i,
    output logic [NUM_INP-1:0]                   inp_ready_o,
    output logic                                 oup_valid_o,
    output logic                                 oup_last_o,
    output logic [DATA_WIDTH-1:0]                oup_data_o,
    output logic [$clog2(NUM_INP)-1:0]           oup_idx_o,
    input  logic                                 oup_ready_i
);

    localparam int IDX_W = $clog2(NUM_INP);
    localparam int CW    = IDX_W + 1;
    localparam logic [CW-1:0]    NUM_W  = CW'(NUM_INP);
    localparam logic [IDX_W-1:0] RR_RST = IDX_W'(NUM_INP - 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

    logic             rr_found;
    logic [IDX_W-1:0] rr_idx;
    logic             sel_valid;
    logic [IDX_W-1:0] sel_idx;
    logic             handshake;

    // Round-robin lookahead: first valid input above rr_q, wrapping to 0.
    always_comb begin
        logic [CW-1:0] cand;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int unsigned off = 1; off <= NUM_INP; off++) begin
            cand = {1'b0, rr_q} + CW'(off);
            if (cand >= NUM_W) cand = cand - NUM_W;
            if (!rr_found && inp_valid_i[cand[IDX_W-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Selected source: the locked input, or the idle-state arbitration winner.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        if (state_q == LOCKED) begin
            sel_idx   = lock_idx_q;
            sel_valid = inp_valid_i[lock_idx_q];
        end else begin
`ifdef STREAM_BURST_ARB_PRIO_EN
            if (inp_valid_i[0]) begin
                sel_valid = 1'b1;
                sel_idx   = '0;
            end else begin
                sel_valid = rr_found;
                sel_idx   = rr_idx;
            end
`else
            sel_valid = rr_found;
            sel_idx   = rr_idx;
`endif
        end
    end

    // Output mux and one-hot ready back to the selected input only.
    always_comb begin
        oup_valid_o = sel_valid;
        oup_last_o  = sel_valid & inp_last_i[sel_idx];
        oup_data_o  = inp_data_i[sel_idx];
        oup_idx_o   = sel_idx;
        inp_ready_o = '0;
        if (sel_valid && oup_ready_i) inp_ready_o[sel_idx] = 1'b1;
    end

    assign handshake = oup_valid_o & oup_ready_i;

    // Next-state logic: lock on any selected beat that does not finish a burst. Flush overrides everything.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        lock_idx_d = lock_idx_q;
        unique case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    rr_d = sel_idx;
                    if (!(handshake && oup_last_o)) begin
                        state_d    = LOCKED;
                        lock_idx_d = sel_idx;
                    end
                end
            end
            LOCKED: begin
                if (handshake && oup_last_o) state_d = IDLE;
            end
        endcase
        if (flush_i) begin
            state_d    = IDLE;
            rr_d       = RR_RST;
            lock_idx_d = '0;
        end
    end

    // State registers. Reset leaves rr_q at the top index so that input 0 wins first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rr_q       <= RR_RST;
            lock_idx_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            rr_q       <= rr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

`ifndef SYNTHESIS
    for (genvar k = 0; k < NUM_INP; k++) begin : g_src_stable
        a_src_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
            inp_valid_i[k] && !inp_ready_o[k] |=>
                inp_valid_i[k] && $stable(inp_last_i[k]) && $stable(inp_data_i[k]));
    end
    a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(inp_ready_o));
    a_valid_src:    assert property (@(posedge clk_i) disable iff (!rst_ni)
        oup_valid_o |-> inp_valid_i[oup_idx_o]);
`endif

endmodule
